// File: rtl/add4_serial_restore.sv
// add4_serial_restore: bit-serial ripple adder that rebuilds the minuend
// A = D + B (mod 2^WIDTH) from a subtractor's difference D and subtrahend B.
// A single full-adder cell plus a carry flip-flop processes one bit per clock,
// LSB first. Start/Done handshake; Sum/Carry hold until the next completion.
//
// Optional build macro ADD4_SERIAL_OVF_EN adds an Ovf output carrying the
// two's-complement overflow of D + B (carry-into-MSB XOR carry-out-of-MSB).
module add4_serial_restore #(
    parameter int WIDTH = 4
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             Start,
    input  logic [WIDTH-1:0] D,
    input  logic [WIDTH-1:0] B,
    output logic             Busy,
    output logic             Done,
    output logic [WIDTH-1:0] Sum,
    output logic             Carry
`ifdef ADD4_SERIAL_OVF_EN
    ,
    output logic             Ovf
`endif
);

    localparam int CNT_W = $clog2(WIDTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SHIFT,
        S_DONE
    } state_t;

    state_t             state_q;
    logic [WIDTH-1:0]   d_q;
    logic [WIDTH-1:0]   b_q;
    // Holds bits 0..WIDTH-2 of the result; the final bit joins it at DONE entry.
    logic [WIDTH-2:0]   res_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               carry_q;
    logic               busy_q;
    logic               done_q;
    logic [WIDTH-1:0]   sum_q;
    logic               cout_q;

    logic               sum_bit_d;
    logic               cout_d;
    logic [WIDTH-1:0]   res_full_d;

    // Single full-adder cell fed by the operand LSBs and the carry flip-flop.
    always_comb begin
        sum_bit_d  = d_q[0] ^ b_q[0] ^ carry_q;
        cout_d     = (d_q[0] & b_q[0]) | (carry_q & (d_q[0] ^ b_q[0]));
        res_full_d = {sum_bit_d, res_q};
    end

`ifdef ADD4_SERIAL_OVF_EN
    logic ovf_q;

    // Signed overflow: carry into the MSB (carry FF now) differs from carry out.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            ovf_q <= 1'b0;
        end else if (state_q == S_SHIFT && cnt_q == CNT_W'(WIDTH - 1)) begin
            ovf_q <= carry_q ^ cout_d;
        end
    end

    assign Ovf = ovf_q;
`endif

    // Control FSM, operand/result shifting and registered handshake outputs.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= S_IDLE;
            d_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
        end else begin
            case (state_q)
                S_SHIFT: begin
                    res_q   <= res_full_d[WIDTH-1:1];
                    carry_q <= cout_d;
                    d_q     <= {1'b0, d_q[WIDTH-1:1]};
                    b_q     <= {1'b0, b_q[WIDTH-1:1]};
                    cnt_q   <= cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(WIDTH - 1)) begin
                        sum_q   <= res_full_d;
                        cout_q  <= cout_d;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= S_DONE;
                    end
                end
                // IDLE and DONE both accept a new request; DONE lasts one cycle.
                default: begin
                    done_q <= 1'b0;
                    if (Start) begin
                        d_q     <= D;
                        b_q     <= B;
                        res_q   <= '0;
                        carry_q <= 1'b0;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= S_SHIFT;
                    end else begin
                        state_q <= S_IDLE;
                    end
                end
            endcase
        end
    end

    assign Busy  = busy_q;
    assign Done  = done_q;
    assign Sum   = sum_q;
    assign Carry = cout_q;

endmodule

// File: tb/tb_add4_serial_restore.sv
// Directed testbench for add4_serial_restore (WIDTH = 4).
module tb_add4_serial_restore;

    localparam int W     = 4;
    localparam int BOUND = 20;

    logic         CLK;
    logic         RST;
    logic         Start;
    logic [W-1:0] D;
    logic [W-1:0] B;
    logic         Busy;
    logic         Done;
    logic [W-1:0] Sum;
    logic         Carry;
`ifdef ADD4_SERIAL_OVF_EN
    logic         Ovf;
`endif

    int checks;
    int errors;

    add4_serial_restore #(.WIDTH(W)) dut (
        .CLK   (CLK),
        .RST   (RST),
        .Start (Start),
        .D     (D),
        .B     (B),
        .Busy  (Busy),
        .Done  (Done),
        .Sum   (Sum),
        .Carry (Carry)
`ifdef ADD4_SERIAL_OVF_EN
        ,
        .Ovf   (Ovf)
`endif
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Present a one-cycle Start with operands; returns 1ns after the sampling edge.
    task automatic do_start(input logic [W-1:0] d, input logic [W-1:0] b);
        @(negedge CLK);
        Start = 1'b1;
        D     = d;
        B     = b;
        @(posedge CLK);
        #1;
        Start = 1'b0;
        D     = ~d;
        B     = ~b;
    endtask

    // Count falling edges until Done is seen (bounded); lat includes the Done cycle.
    task automatic wait_done(output int lat, output int busy_cnt, output bit got);
        lat      = 0;
        busy_cnt = 0;
        got      = 1'b0;
        while (!got && lat < BOUND) begin
            @(negedge CLK);
            lat++;
            if (Busy === 1'b1) busy_cnt++;
            if (Done === 1'b1) got = 1'b1;
        end
    endtask

    task automatic test_reset();
        RST   = 1'b1;
        Start = 1'b0;
        D     = '0;
        B     = '0;
        repeat (2) @(negedge CLK);
        checks++;
        if ({Busy, Done, Sum, Carry} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got busy=%b done=%b sum=%h carry=%b expected all 0",
                     Busy, Done, Sum, Carry);
        end
        RST = 1'b0;
        @(negedge CLK);
        checks++;
        if ({Busy, Done, Sum, Carry} !== '0) begin
            errors++;
            $display("FAIL reset_idle: got busy=%b done=%b sum=%h carry=%b expected all 0",
                     Busy, Done, Sum, Carry);
        end
    endtask

    task automatic test_basic();
        int lat, bc;
        bit got;
        do_start(4'b0101, 4'b0011);
        wait_done(lat, bc, got);
        checks++;
        if (!got || lat != 5) begin
            errors++;
            $display("FAIL basic_latency: got done=%b after %0d cycles expected 5", got, lat);
        end
        checks++;
        if (bc != 4) begin
            errors++;
            $display("FAIL basic_busy_cycles: got %0d expected 4", bc);
        end
        checks++;
        if (Sum !== 4'b1000 || Carry !== 1'b0 || Busy !== 1'b0) begin
            errors++;
            $display("FAIL basic_result: got sum=%b carry=%b busy=%b expected 1000 0 0",
                     Sum, Carry, Busy);
        end
        @(negedge CLK);
        checks++;
        if (Done !== 1'b0 || Sum !== 4'b1000) begin
            errors++;
            $display("FAIL basic_done_pulse_hold: got done=%b sum=%b expected 0 1000", Done, Sum);
        end
    endtask

    task automatic test_inverse();
        int lat, bc;
        bit got;
        logic [W-1:0] dd;
        logic [W:0]   full;
        do_start(4'b1101, 4'b1100);
        wait_done(lat, bc, got);
        checks++;
        if (!got || Sum !== 4'b1001 || Carry !== 1'b1) begin
            errors++;
            $display("FAIL inverse_example: got done=%b sum=%b carry=%b expected 1 1001 1",
                     got, Sum, Carry);
        end
        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                dd   = W'((a - b) & 15);
                full = {1'b0, dd} + (W + 1)'(b);
                do_start(dd, W'(b));
                wait_done(lat, bc, got);
                checks++;
                if (!got || Sum !== W'(a) || Carry !== full[W]) begin
                    errors++;
                    $display("FAIL inverse_sweep a=%0d b=%0d: got done=%b sum=%0d carry=%b expected sum=%0d carry=%b",
                             a, b, got, Sum, Carry, a, full[W]);
                end
            end
        end
    endtask

    task automatic test_wrap();
        int lat, bc;
        bit got;
        do_start(4'b1111, 4'b0001);
        wait_done(lat, bc, got);
        checks++;
        if (!got || Sum !== 4'b0000 || Carry !== 1'b1) begin
            errors++;
            $display("FAIL wrap_f_plus_1: got done=%b sum=%b carry=%b expected 1 0000 1",
                     got, Sum, Carry);
        end
        do_start(4'b0000, 4'b0000);
        wait_done(lat, bc, got);
        checks++;
        if (!got || Sum !== 4'b0000 || Carry !== 1'b0) begin
            errors++;
            $display("FAIL wrap_zero: got done=%b sum=%b carry=%b expected 1 0000 0",
                     got, Sum, Carry);
        end
    endtask

    task automatic test_start_in_shift();
        int lat, bc;
        bit got;
        do_start(4'b0010, 4'b0011);
        @(negedge CLK);
        @(negedge CLK);
        Start = 1'b1;
        D     = 4'b1111;
        B     = 4'b1111;
        @(negedge CLK);
        Start = 1'b0;
        wait_done(lat, bc, got);
        checks++;
        if (!got || lat != 2 || Sum !== 4'b0101 || Carry !== 1'b0) begin
            errors++;
            $display("FAIL start_in_shift: got done=%b lat=%0d sum=%b carry=%b expected 1 2 0101 0",
                     got, lat, Sum, Carry);
        end
        @(negedge CLK);
        @(negedge CLK);
        checks++;
        if (Busy !== 1'b0 || Done !== 1'b0 || Sum !== 4'b0101) begin
            errors++;
            $display("FAIL start_in_shift_idle: got busy=%b done=%b sum=%b expected 0 0 0101",
                     Busy, Done, Sum);
        end
    endtask

    task automatic test_back_to_back();
        int lat, bc;
        bit got;
        do_start(4'b0001, 4'b0010);
        wait_done(lat, bc, got);
        checks++;
        if (!got || Sum !== 4'b0011) begin
            errors++;
            $display("FAIL b2b_first: got done=%b sum=%b expected 1 0011", got, Sum);
        end
        // Still in the DONE cycle: request the next operation here.
        Start = 1'b1;
        D     = 4'b0100;
        B     = 4'b0100;
        @(posedge CLK);
        #1;
        Start = 1'b0;
        D     = 4'b0000;
        B     = 4'b0000;
        checks++;
        if (Busy !== 1'b1 || Done !== 1'b0 || Sum !== 4'b0011) begin
            errors++;
            $display("FAIL b2b_hold: got busy=%b done=%b sum=%b expected 1 0 0011", Busy, Done, Sum);
        end
        wait_done(lat, bc, got);
        checks++;
        if (!got || lat != 5 || Sum !== 4'b1000 || Carry !== 1'b0) begin
            errors++;
            $display("FAIL b2b_second: got done=%b lat=%0d sum=%b carry=%b expected 1 5 1000 0",
                     got, lat, Sum, Carry);
        end
    endtask

    task automatic test_reset_mid();
        int lat, bc;
        bit got;
        int done_seen;
        do_start(4'b0111, 4'b0111);
        @(posedge CLK);
        @(posedge CLK);
        #2;
        RST = 1'b1;
        #1;
        checks++;
        if ({Busy, Done, Sum, Carry} !== '0) begin
            errors++;
            $display("FAIL reset_mid_async: got busy=%b done=%b sum=%b carry=%b expected all 0",
                     Busy, Done, Sum, Carry);
        end
        @(negedge CLK);
        RST       = 1'b0;
        done_seen = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge CLK);
            if (Done === 1'b1 || Busy === 1'b1) done_seen++;
        end
        checks++;
        if (done_seen != 0) begin
            errors++;
            $display("FAIL reset_mid_no_done: got %0d active cycles expected 0", done_seen);
        end
        do_start(4'b0110, 4'b1001);
        wait_done(lat, bc, got);
        checks++;
        if (!got || lat != 5 || Sum !== 4'b1111 || Carry !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_recover: got done=%b lat=%0d sum=%b carry=%b expected 1 5 1111 0",
                     got, lat, Sum, Carry);
        end
    endtask

`ifdef ADD4_SERIAL_OVF_EN
    task automatic test_ovf();
        int lat, bc;
        bit got;
        do_start(4'b0111, 4'b0001);
        wait_done(lat, bc, got);
        checks++;
        if (!got || Sum !== 4'b1000 || Carry !== 1'b0 || Ovf !== 1'b1) begin
            errors++;
            $display("FAIL ovf_pos: got done=%b sum=%b carry=%b ovf=%b expected 1 1000 0 1",
                     got, Sum, Carry, Ovf);
        end
        do_start(4'b1111, 4'b0001);
        wait_done(lat, bc, got);
        checks++;
        if (!got || Sum !== 4'b0000 || Carry !== 1'b1 || Ovf !== 1'b0) begin
            errors++;
            $display("FAIL ovf_none: got done=%b sum=%b carry=%b ovf=%b expected 1 0000 1 0",
                     got, Sum, Carry, Ovf);
        end
    endtask
`endif

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_basic();
        test_wrap();
        test_start_in_shift();
        test_back_to_back();
        test_reset_mid();
`ifdef ADD4_SERIAL_OVF_EN
        test_ovf();
`endif
        test_inverse();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
